// File: rtl/decode_if.sv
// Decode stage bus: instruction handshake, write-back port and ID/EX outputs.
interface decode_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              flush;
  logic              wb_en;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] ALU_read_data_1;
  logic [DATA_W-1:0] ALU_read_data_2;
  logic [DATA_W-1:0] immediate;
  logic [5:0]        Function;
  logic [2:0]        ALUop;
  logic              ALUsrc;
  logic              RegWrite;
  logic              MemRead;
  logic              MemWrite;
  logic              Branch;
  logic [4:0]        write_reg;
  logic              ex_valid;
  logic              illegal;

  modport master (
    output instr, instr_valid, flush, wb_en, wb_reg, wb_data,
    input  instr_ready, ALU_read_data_1, ALU_read_data_2, immediate, Function,
           ALUop, ALUsrc, RegWrite, MemRead, MemWrite, Branch, write_reg,
           ex_valid, illegal
  );

  modport slave (
    input  instr, instr_valid, flush, wb_en, wb_reg, wb_data,
    output instr_ready, ALU_read_data_1, ALU_read_data_2, immediate, Function,
           ALUop, ALUsrc, RegWrite, MemRead, MemWrite, Branch, write_reg,
           ex_valid, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: register file with write-back bypass, opcode
// decode, load-use stall detection and the ID/EX pipeline register.
module decode_stage #(
  parameter int DATA_W = 32
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_SLT   = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [DATA_W-1:0] rf [32];

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  assign opcode = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rt     = bus.instr[20:16];
  assign rd     = bus.instr[15:11];

  function automatic logic signed [DATA_W-1:0] sign_ext16(input logic [15:0] v);
    logic signed [DATA_W-1:0] s;
    s = {{(DATA_W-16){v[15]}}, v};
    return s;
  endfunction

  logic [DATA_W-1:0] rs_data, rt_data;
  logic              dec_legal, uses_rt;
  logic [2:0]        dec_aluop;
  logic              dec_alusrc, dec_regwrite, dec_memread, dec_memwrite, dec_branch;
  logic [4:0]        dec_wreg;
  logic [5:0]        dec_func;

  logic              ex_valid_p1, illegal_p1;
  logic [DATA_W-1:0] rd1_p1, rd2_p1, imm_p1;
  logic [5:0]        func_p1;
  logic [2:0]        aluop_p1;
  logic              alusrc_p1, regwrite_p1, memread_p1, memwrite_p1, branch_p1;
  logic [4:0]        wreg_p1;
  logic              hazard, accept;

  // Combinational operand read; r0 is hardwired and same-cycle write-back wins.
  always_comb begin
    rs_data = rf[rs];
    rt_data = rf[rt];
    if (bus.wb_en && bus.wb_reg == rs) rs_data = bus.wb_data;
    if (bus.wb_en && bus.wb_reg == rt) rt_data = bus.wb_data;
    if (rs == 5'd0) rs_data = '0;
    if (rt == 5'd0) rt_data = '0;
  end

  // Opcode decode into control fields for the ID/EX register.
  always_comb begin
    dec_legal    = 1'b1;
    uses_rt      = 1'b0;
    dec_aluop    = 3'b000;
    dec_alusrc   = 1'b0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_branch   = 1'b0;
    dec_wreg     = 5'd0;
    dec_func     = 6'd0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1; dec_regwrite = 1'b1; dec_wreg = rd; dec_func = bus.instr[5:0];
      end
      OP_ADDI: begin
        dec_aluop = 3'b001; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_wreg = rt;
      end
      OP_SLT: begin
        uses_rt = 1'b1; dec_aluop = 3'b010; dec_regwrite = 1'b1; dec_wreg = rd;
      end
      OP_LW: begin
        dec_aluop = 3'b001; dec_alusrc = 1'b1; dec_memread = 1'b1;
        dec_regwrite = 1'b1; dec_wreg = rt;
      end
      OP_SW: begin
        uses_rt = 1'b1; dec_aluop = 3'b001; dec_alusrc = 1'b1; dec_memwrite = 1'b1;
      end
      OP_BEQ: begin
        uses_rt = 1'b1; dec_aluop = 3'b011; dec_branch = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // A load in EX whose destination feeds this instruction forces one bubble.
  assign hazard = ex_valid_p1 & memread_p1 & (wreg_p1 != 5'd0) &
                  ((wreg_p1 == rs) | (uses_rt & (wreg_p1 == rt)));
  assign bus.instr_ready = ~hazard;
  assign accept = bus.instr_valid & ~hazard & ~bus.flush;

  // Register file write port; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.wb_en && bus.wb_reg != 5'd0) begin
      rf[bus.wb_reg] <= bus.wb_data;
    end
  end

  // ---- stage boundary: ID -> EX ----
  // ID/EX register: decoded fields on a legal accept, otherwise an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_p1 <= 1'b0; illegal_p1 <= 1'b0;
      rd1_p1 <= '0; rd2_p1 <= '0; imm_p1 <= '0; func_p1 <= '0;
      aluop_p1 <= '0; alusrc_p1 <= 1'b0; regwrite_p1 <= 1'b0;
      memread_p1 <= 1'b0; memwrite_p1 <= 1'b0; branch_p1 <= 1'b0; wreg_p1 <= '0;
    end else begin
      illegal_p1 <= accept & ~dec_legal;
      if (accept && dec_legal) begin
        ex_valid_p1 <= 1'b1;
        rd1_p1 <= rs_data; rd2_p1 <= rt_data; imm_p1 <= sign_ext16(bus.instr[15:0]);
        func_p1 <= dec_func; aluop_p1 <= dec_aluop; alusrc_p1 <= dec_alusrc;
        regwrite_p1 <= dec_regwrite; memread_p1 <= dec_memread;
        memwrite_p1 <= dec_memwrite; branch_p1 <= dec_branch; wreg_p1 <= dec_wreg;
      end else begin
        ex_valid_p1 <= 1'b0;
        rd1_p1 <= '0; rd2_p1 <= '0; imm_p1 <= '0; func_p1 <= '0;
        aluop_p1 <= '0; alusrc_p1 <= 1'b0; regwrite_p1 <= 1'b0;
        memread_p1 <= 1'b0; memwrite_p1 <= 1'b0; branch_p1 <= 1'b0; wreg_p1 <= '0;
      end
    end
  end

  assign bus.ex_valid        = ex_valid_p1;
  assign bus.illegal         = illegal_p1;
  assign bus.ALU_read_data_1 = rd1_p1;
  assign bus.ALU_read_data_2 = rd2_p1;
  assign bus.immediate       = imm_p1;
  assign bus.Function        = func_p1;
  assign bus.ALUop           = aluop_p1;
  assign bus.ALUsrc          = alusrc_p1;
  assign bus.RegWrite        = regwrite_p1;
  assign bus.MemRead         = memread_p1;
  assign bus.MemWrite        = memwrite_p1;
  assign bus.Branch          = branch_p1;
  assign bus.write_reg       = wreg_p1;
endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed literal checks plus randomized traffic
// compared every cycle against a table-driven reference model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_if bus ();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       legal;
    logic [2:0] aluop;
    logic       alusrc, rw, mr, mw, br, ut;
    logic [1:0] dest;   // 0 none, 1 rt, 2 rd
  } row_t;
  row_t tab [64];

  typedef struct {
    logic        ex_valid, illegal;
    logic [31:0] a1, a2, imm;
    logic [5:0]  func;
    logic [2:0]  aluop;
    logic        alusrc, regwrite, memread, memwrite, branch;
    logic [4:0]  wreg;
  } exp_t;
  exp_t m;
  logic [31:0] m_rf [32];

  function automatic logic m_ready(input logic [31:0] ins);
    row_t r;
    r = tab[ins[31:26]];
    return !(m.ex_valid && m.memread && m.wreg != 0 &&
             (m.wreg == ins[25:21] || (r.legal && r.ut && m.wreg == ins[20:16])));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wr == idx) return wd;
    return m_rf[idx];
  endfunction

  task automatic m_step(input logic r, input logic [31:0] ins, input logic v, input logic f,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
    exp_t n;
    row_t t;
    logic acc;
    n = '{default: '0};
    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      acc = v && m_ready(ins) && !f;
      t = tab[ins[31:26]];
      if (acc && !t.legal) n.illegal = 1'b1;
      if (acc && t.legal) begin
        n.ex_valid = 1'b1;
        n.a1 = m_read(ins[25:21], we, wr, wd);
        n.a2 = m_read(ins[20:16], we, wr, wd);
        n.imm = {{16{ins[15]}}, ins[15:0]};
        n.func = (ins[31:26] == 6'd0) ? ins[5:0] : 6'd0;
        n.aluop = t.aluop; n.alusrc = t.alusrc; n.regwrite = t.rw;
        n.memread = t.mr; n.memwrite = t.mw; n.branch = t.br;
        n.wreg = (t.dest == 2'd1) ? ins[20:16] : (t.dest == 2'd2) ? ins[15:11] : 5'd0;
      end
      if (we && wr != 0) m_rf[wr] = wd;
    end
    m = n;
  endtask

  // Compare process: step the model on each edge, check every output after it.
  initial begin
    logic        c_rst, c_v, c_f, c_we;
    logic [31:0] c_ins, c_wd;
    logic [4:0]  c_wr;
    for (int i = 0; i < 64; i++) tab[i] = '0;
    //             legal aluop  src rw mr mw br ut dest
    tab[6'h00] = {1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    tab[6'h01] = {1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tab[6'h02] = {1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    tab[6'h23] = {1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    tab[6'h2B] = {1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
    tab[6'h04] = {1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    m = '{default: '0};
    forever begin
      @(posedge clk);
      c_rst = rst; c_ins = bus.instr; c_v = bus.instr_valid; c_f = bus.flush;
      c_we = bus.wb_en; c_wr = bus.wb_reg; c_wd = bus.wb_data;
      m_step(c_rst, c_ins, c_v, c_f, c_we, c_wr, c_wd);
      #1;
      chk("ex_valid",  bus.ex_valid,        m.ex_valid);
      chk("illegal",   bus.illegal,         m.illegal);
      chk("rd_data_1", bus.ALU_read_data_1, m.a1);
      chk("rd_data_2", bus.ALU_read_data_2, m.a2);
      chk("immediate", bus.immediate,       m.imm);
      chk("Function",  bus.Function,        m.func);
      chk("ALUop",     bus.ALUop,           m.aluop);
      chk("ALUsrc",    bus.ALUsrc,          m.alusrc);
      chk("RegWrite",  bus.RegWrite,        m.regwrite);
      chk("MemRead",   bus.MemRead,         m.memread);
      chk("MemWrite",  bus.MemWrite,        m.memwrite);
      chk("Branch",    bus.Branch,          m.branch);
      chk("write_reg", bus.write_reg,       m.wreg);
      @(negedge clk);
      #1;
      chk("instr_ready", bus.instr_ready, m_ready(bus.instr));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic f,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    bus.instr = ins; bus.instr_valid = v; bus.flush = f;
    bus.wb_en = we; bus.wb_reg = wr; bus.wb_data = wd;
  endtask

  task automatic after_edge;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{6'h00, 6'h01, 6'h02, 6'h23, 6'h2B, 6'h04, 6'h3F};
    rst = 1'b1;
    bus.instr = '0; bus.instr_valid = 1'b0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("lit_rst_ex_valid", bus.ex_valid, 0);
    chk("lit_rst_ready", bus.instr_ready, 1);
    chk("lit_rst_regwrite", bus.RegWrite, 0);
    @(negedge clk); rst = 1'b0;

    // R-type reading r1=7, r2=5
    drive(32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd7);
    drive(32'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd5);
    drive(rtype(5'd1, 5'd2, 5'd3, 6'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    after_edge;
    chk("lit_r_a1", bus.ALU_read_data_1, 32'd7);
    chk("lit_r_a2", bus.ALU_read_data_2, 32'd5);
    chk("lit_r_aluop", bus.ALUop, 3'b000);
    chk("lit_r_alusrc", bus.ALUsrc, 1'b0);
    chk("lit_r_wreg", bus.write_reg, 5'd3);
    chk("lit_r_regwrite", bus.RegWrite, 1'b1);
    chk("lit_r_ex_valid", bus.ex_valid, 1'b1);

    // ADDI with negative immediate
    drive(itype(6'h01, 5'd1, 5'd4, 16'hFFF4), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    after_edge;
    chk("lit_addi_imm", bus.immediate, 32'hFFFF_FFF4);
    chk("lit_addi_aluop", bus.ALUop, 3'b001);
    chk("lit_addi_alusrc", bus.ALUsrc, 1'b1);
    chk("lit_addi_wreg", bus.write_reg, 5'd4);
    chk("lit_addi_func", bus.Function, 6'd0);

    // load-use stall
    drive(itype(6'h23, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    after_edge;
    chk("lit_lw_memread", bus.MemRead, 1'b1);
    drive(rtype(5'd5, 5'd0, 5'd7, 6'h20), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("lit_stall_ready", bus.instr_ready, 1'b0);
    after_edge;
    chk("lit_stall_bubble", bus.ex_valid, 1'b0);
    after_edge;
    chk("lit_stall_resume", bus.ex_valid, 1'b1);
    chk("lit_stall_wreg", bus.write_reg, 5'd7);

    // write-back bypass
    drive(itype(6'h01, 5'd6, 5'd8, 16'd0), 1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_000F);
    after_edge;
    chk("lit_bypass_a1", bus.ALU_read_data_1, 32'd15);

    // flush, r0 write, illegal opcode
    drive(itype(6'h01, 5'd1, 5'd9, 16'd1), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    after_edge;
    chk("lit_flush_ex_valid", bus.ex_valid, 1'b0);
    chk("lit_flush_regwrite", bus.RegWrite, 1'b0);
    drive(32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd9);
    drive(rtype(5'd0, 5'd0, 5'd10, 6'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    after_edge;
    chk("lit_r0_a1", bus.ALU_read_data_1, 32'd0);
    drive({6'h3F, 26'd0}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    after_edge;
    chk("lit_illegal_set", bus.illegal, 1'b1);
    chk("lit_illegal_bubble", bus.ex_valid, 1'b0);
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    after_edge;
    chk("lit_illegal_clear", bus.illegal, 1'b0);

    // reset mid-stream
    drive(rtype(5'd1, 5'd2, 5'd11, 6'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    after_edge;
    chk("lit_pre_rst_valid", bus.ex_valid, 1'b1);
    drive(rtype(5'd1, 5'd2, 5'd12, 6'd0), 1'b1, 1'b0, 1'b1, 5'd3, 32'd99);
    rst = 1'b1;
    after_edge;
    chk("lit_midrst_valid", bus.ex_valid, 1'b0);
    chk("lit_midrst_a1", bus.ALU_read_data_1, 32'd0);
    chk("lit_midrst_wreg", bus.write_reg, 5'd0);
    @(negedge clk); rst = 1'b0;
    drive(rtype(5'd1, 5'd2, 5'd13, 6'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    after_edge;
    chk("lit_post_rst_a1", bus.ALU_read_data_1, 32'd0);
    chk("lit_post_rst_valid", bus.ex_valid, 1'b1);

    // randomized traffic, small register range so hazards and bypasses occur
    for (int k = 0; k < 800; k++) begin
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 19) == 0) op = 6'($urandom);
      drive({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom)},
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom);
      rst = ($urandom_range(0, 99) == 0);
    end
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
